// File: rtl/img_pkg.sv
// Shared image-pipeline types and default frame geometry for the window
// generator and the filters it feeds.
package img_pkg;

    localparam int IMG_HDISP_DFLT = 640;
    localparam int IMG_VDISP_DFLT = 480;
    localparam int PIXEL_WIDTH    = 8;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    typedef struct packed {
        pixel_t m11;
        pixel_t m12;
        pixel_t m13;
        pixel_t m21;
        pixel_t m22;
        pixel_t m23;
        pixel_t m31;
        pixel_t m32;
        pixel_t m33;
    } window_t;

endpackage

// File: rtl/line_delay_ram.sv
// Circular line-delay memory: on each clken, stores din and presents the
// value written DEPTH accepts earlier, ready for the following accept.
module line_delay_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clken,
    input  logic             restart,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic             rd_en;
    logic [WIDTH-1:0] dout_q;

    // The read prefetches the slot the next accept will overwrite, so dout
    // already holds the DEPTH-old pixel when that accept arrives.
    always_comb begin
        wr_addr  = restart ? '0 : wr_ptr_q;
        wr_ptr_d = wr_addr;
        if (clken) begin
            wr_ptr_d = (wr_addr == LAST) ? '0 : wr_addr + AW'(1);
        end
        rd_addr = wr_ptr_d;
        rd_en   = clken | restart;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (clken) begin
            mem[wr_addr] <= din;
        end
        if (rd_en) begin
            dout_q <= mem[rd_addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two chained line delays supply rows r-1 and
// r-2, three column shifters form the window, out-of-image taps read as 0.
module matrix_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_HDISP   = IMG_HDISP_DFLT,
    parameter int IMG_VDISP   = IMG_VDISP_DFLT,
    parameter int INPUT_WIDTH = PIXEL_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_vsync,
    input  logic                   in_href,
    input  logic                   in_clken,
    input  logic [INPUT_WIDTH-1:0] in_pixel,
    output logic                   out_vsync,
    output logic                   out_href,
    output logic                   out_clken,
    output logic [INPUT_WIDTH-1:0] m11,
    output logic [INPUT_WIDTH-1:0] m12,
    output logic [INPUT_WIDTH-1:0] m13,
    output logic [INPUT_WIDTH-1:0] m21,
    output logic [INPUT_WIDTH-1:0] m22,
    output logic [INPUT_WIDTH-1:0] m23,
    output logic [INPUT_WIDTH-1:0] m31,
    output logic [INPUT_WIDTH-1:0] m32,
    output logic [INPUT_WIDTH-1:0] m33
);

    localparam int COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_HDISP - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);

    logic                   acc;
    logic                   href_q, href_d, vsync_q, vsync_d, clken_q, clken_d;
    logic                   href_rise, href_fall, vsync_rise;
    logic [COL_W-1:0]       col_cnt_q, col_cnt_d, cur_col;
    logic [ROW_W-1:0]       row_cnt_q, row_cnt_d, cur_row;
    logic                   frame_live_q, frame_live_d, frame_live;
    logic [INPUT_WIDTH-1:0] row1_pix, row2_pix;
    logic [INPUT_WIDTH-1:0] newest [3];
    logic [INPUT_WIDTH-1:0] win_q [3][3];
    logic [INPUT_WIDTH-1:0] win_d [3][3];
    logic [INPUT_WIDTH-1:0] tap_q [3][3];
    logic [INPUT_WIDTH-1:0] tap_d [3][3];
    logic [2:0]             row_ok, col_ok;

    assign acc = in_href & in_clken;

    line_delay_ram #(.DEPTH(IMG_HDISP), .WIDTH(INPUT_WIDTH)) u_row_a (
        .clock   (clock),
        .reset   (reset),
        .clken   (acc),
        .restart (vsync_rise),
        .din     (in_pixel),
        .dout    (row1_pix)
    );

    line_delay_ram #(.DEPTH(IMG_HDISP), .WIDTH(INPUT_WIDTH)) u_row_b (
        .clock   (clock),
        .reset   (reset),
        .clken   (acc),
        .restart (vsync_rise),
        .din     (row1_pix),
        .dout    (row2_pix)
    );

    // cur_col/cur_row are the coordinates of a pixel accepted this cycle,
    // already accounting for a line or frame start in the same cycle.
    always_comb begin
        href_d     = in_href;
        vsync_d    = in_vsync;
        clken_d    = acc;
        href_rise  = in_href & ~href_q;
        href_fall  = ~in_href & href_q;
        vsync_rise = in_vsync & ~vsync_q;

        cur_col   = href_rise ? '0 : col_cnt_q;
        col_cnt_d = cur_col;
        if (acc && (cur_col != COL_MAX)) begin
            col_cnt_d = cur_col + COL_W'(1);
        end

        cur_row   = vsync_rise ? '0 : row_cnt_q;
        row_cnt_d = cur_row;
        if (href_fall && !vsync_rise && (cur_row != ROW_MAX)) begin
            row_cnt_d = cur_row + ROW_W'(1);
        end

        // Taps stay zero after a reset until a frame start is seen.
        frame_live   = frame_live_q | vsync_rise;
        frame_live_d = frame_live;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_mask
        assign row_ok[gi] = (int'(cur_row) >= 2 - gi);
        assign col_ok[gi] = (int'(cur_col) >= 2 - gi);
    end

    always_comb begin
        newest[0] = row2_pix;
        newest[1] = row1_pix;
        newest[2] = in_pixel;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_d[i][j] = win_q[i][j];
                tap_d[i][j] = tap_q[i][j];
            end
        end
        if (acc) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
                win_d[i][2] = newest[i];
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    tap_d[i][j] = (frame_live && row_ok[i] && col_ok[j]) ? win_d[i][j] : '0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            clken_q      <= 1'b0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            frame_live_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                    tap_q[i][j] <= '0;
                end
            end
        end else begin
            href_q       <= href_d;
            vsync_q      <= vsync_d;
            clken_q      <= clken_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            frame_live_q <= frame_live_d;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= win_d[i][j];
                    tap_q[i][j] <= tap_d[i][j];
                end
            end
        end
    end

    assign out_vsync = vsync_q;
    assign out_href  = href_q;
    assign out_clken = clken_q;
    assign m11 = tap_q[0][0];
    assign m12 = tap_q[0][1];
    assign m13 = tap_q[0][2];
    assign m21 = tap_q[1][0];
    assign m22 = tap_q[1][1];
    assign m23 = tap_q[1][2];
    assign m31 = tap_q[2][0];
    assign m32 = tap_q[2][1];
    assign m33 = tap_q[2][2];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen on a 4x4 frame with P(r,c) = seed + 16r + c.
module tb_matrix_3x3_gen;

    localparam int HD = 4;
    localparam int VD = 4;

    localparam logic [71:0] WIN_R2C3 = 72'h010203_111213_212223;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       in_vsync = 1'b0;
    logic       in_href  = 1'b0;
    logic       in_clken = 1'b0;
    logic [7:0] in_pixel = 8'h00;
    logic       out_vsync, out_href, out_clken;
    logic [7:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
    logic [71:0] taps;
    logic [71:0] cap [0:VD-1][0:HD-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    assign taps = {m11, m12, m13, m21, m22, m23, m31, m32, m33};

    matrix_3x3_gen #(.IMG_HDISP(HD), .IMG_VDISP(VD), .INPUT_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_vsync  (in_vsync),
        .in_href   (in_href),
        .in_clken  (in_clken),
        .in_pixel  (in_pixel),
        .out_vsync (out_vsync),
        .out_href  (out_href),
        .out_clken (out_clken),
        .m11(m11), .m12(m12), .m13(m13),
        .m21(m21), .m22(m22), .m23(m23),
        .m31(m31), .m32(m32), .m33(m33)
    );

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step(input logic h, input logic ce, input logic [7:0] p);
        in_href  = h;
        in_clken = ce;
        in_pixel = p;
        @(posedge clock);
        #1;
    endtask

    task automatic send_line(input logic [7:0] seed, input int r, input int gap_after, input int extra);
        for (int c = 0; c < HD; c++) begin
            step(1'b1, 1'b1, seed + 8'(16 * r + c));
            cap[r][c] = taps;
            if (gap_after >= 0 && c == gap_after + 1)
                check_val("gap_pulse_b", {71'b0, out_clken}, 72'd1);
            if (c == gap_after) begin
                check_val("gap_pulse_a", {71'b0, out_clken}, 72'd1);
                step(1'b1, 1'b0, 8'hEE);
                check_val("gap_idle", {71'b0, out_clken}, 72'd0);
            end
        end
        for (int e = 0; e < extra; e++) begin
            step(1'b1, 1'b1, 8'h77);
            check_val("col_sat", {70'b0, dut.col_cnt_q}, 72'd3);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_frame();
        in_vsync = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        in_vsync = 1'b0;
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] seed, input int gap_row, input int long_row);
        start_frame();
        for (int r = 0; r < VD; r++)
            send_line(seed, r, (r == gap_row) ? 1 : -1, (r == long_row) ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Inputs active during reset must not move anything.
        in_href  = 1'b1;
        in_clken = 1'b1;
        in_pixel = 8'h5A;
        repeat (3) @(posedge clock);
        #1;
        check_val("reset_taps", taps, 72'h0);
        check_val("reset_ctrl", {69'b0, out_vsync, out_href, out_clken}, 72'h0);
        in_href  = 1'b0;
        in_clken = 1'b0;
        reset    = 1'b0;
        step(1'b0, 1'b0, 8'h00);

        // Frame A, row 2 carries a clken gap between columns 1 and 2.
        send_frame(8'h00, 2, -1);
        check_val("r0c0_zero",   cap[0][0], 72'h0);
        check_val("r0c3_window", cap[0][3], 72'h000000_000000_010203);
        check_val("r1c1_window", cap[1][1], 72'h000000_000001_001011);
        check_val("r2c3_gapped", cap[2][3], WIN_R2C3);
        step(1'b0, 1'b0, 8'h00);
        check_val("hold_after_line", taps, 72'h111213_212223_313233);
        check_val("clken_idle", {71'b0, out_clken}, 72'd0);

        // Frame B follows directly with different data.
        send_frame(8'h80, -1, -1);
        check_val("f2_r0c3", cap[0][3], 72'h000000_000000_818283);
        check_val("f2_r1c0", cap[1][0], 72'h000000_000080_000090);
        check_val("f2_r1c3", cap[1][3], 72'h000000_818283_919293);
        check_val("f2_r2c3", cap[2][3], 72'h818283_919293_a1a2a3);

        // Reset pulse at row 2, column 1.
        start_frame();
        send_line(8'h40, 0, -1, 0);
        send_line(8'h40, 1, -1, 0);
        step(1'b1, 1'b1, 8'h60);
        in_pixel = 8'h61;
        #1 reset = 1'b1;
        #1;
        check_val("rst_taps_imm", taps, 72'h0);
        check_val("rst_ctrl_imm", {69'b0, out_vsync, out_href, out_clken}, 72'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        step(1'b1, 1'b1, 8'h62);
        step(1'b1, 1'b1, 8'h63);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        send_line(8'h40, 3, -1, 0);
        check_val("post_rst_zero", cap[3][3], 72'h0);
        send_frame(8'h00, -1, -1);
        check_val("rst_recover", cap[2][3], WIN_R2C3);

        // Over-long row 1: the rest of that frame is shifted by one accept.
        send_frame(8'h00, -1, 1);
        check_val("long_misalign", cap[2][3], 72'h020310_121377_212223);
        check_val("long_no_x", {71'b0, $isunknown(taps)}, 72'd0);
        send_frame(8'h00, -1, -1);
        check_val("long_realign", cap[2][3], WIN_R2C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
